load_scoreboard: RTL and testbench

LOAD_SCOREBOARD -- requirements
Module: load_scoreboard

---
 rtl/load_scoreboard_pkg.sv | 17 +
 rtl/tag_fifo.sv | 61 ++++++
 rtl/load_scoreboard.sv | 122 ++++++++++++
 tb/tb_load_scoreboard.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/load_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// load_scoreboard_pkg
//   Shared constants and types for the load scoreboard and its tag FIFO.
//   REG_W         : width of a register index
//   NUM_REGS      : number of architectural registers tracked
//   DEFAULT_DEPTH : default number of outstanding loads
//   reg_idx_t     : register index type
// -----------------------------------------------------------------------------
package load_scoreboard_pkg;

   localparam int unsigned REG_W         = 5;
   localparam int unsigned NUM_REGS      = 32;
   localparam int unsigned DEFAULT_DEPTH = 4;

   typedef logic [REG_W-1:0] reg_idx_t;

endpackage : load_scoreboard_pkg

// File: rtl/tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
//   In-order FIFO of destination-register tags for outstanding loads.
//   Pointers carry one extra wrap bit so full and empty are distinguishable.
//   Ports:
//     clk, rst  : rising-edge clock, async active-high reset (clears pointers)
//     push      : write push_tag at the tail (caller guarantees room or pop)
//     push_tag  : tag to write
//     pop       : retire the head entry (caller guarantees not empty)
//     full      : DEPTH entries held
//     empty     : no entries held
//     head      : tag at the head (undefined content when empty)
// -----------------------------------------------------------------------------
module tag_fifo
   import load_scoreboard_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  reg_idx_t push_tag,
   input  logic     pop,
   output logic     full,
   output logic     empty,
   output reg_idx_t head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   reg_idx_t      r_mem [DEPTH];
   logic [AW-1:0] w_wr_idx;
   logic [AW-1:0] w_rd_idx;

   assign w_wr_idx = r_wr_ptr[AW-1:0];
   assign w_rd_idx = r_rd_ptr[AW-1:0];

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign head  = r_mem[w_rd_idx];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   // Push while full with a pop writes into the slot being retired this
   // same edge; the head was already consumed combinationally.
   always_ff @(posedge clk) begin
      if (push) r_mem[w_wr_idx] <= push_tag;
   end

endmodule : tag_fifo

// File: rtl/load_scoreboard.sv
// -----------------------------------------------------------------------------
// load_scoreboard
//   Tracks outstanding loads (returned in issue order) and stalls the front
//   end when an ID-stage source register still awaits load data, or when the
//   tracker is full.
//   Ports:
//     clk, rst          : rising-edge clock, async active-high reset
//     iss_valid, iss_rd : load issued this cycle and its destination register
//     ID_RegRs/Rt       : ID-stage source registers
//     ID_UseRs/Rt       : ID-stage instruction reads Rs / Rt
//     resp_valid        : oldest outstanding load returns this cycle
//     resp_rd           : destination of oldest outstanding load (0 if none)
//     stall             : freeze PC/IF/ID
//     full, empty       : tracker occupancy
//     pending           : bit n set while register n awaits a load
//     err               : sticky protocol violation (overflow / underflow)
// -----------------------------------------------------------------------------
module load_scoreboard
   import load_scoreboard_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                iss_valid,
   input  reg_idx_t            iss_rd,
   input  reg_idx_t            ID_RegRs,
   input  reg_idx_t            ID_RegRt,
   input  logic                ID_UseRs,
   input  logic                ID_UseRt,
   input  logic                resp_valid,
   output reg_idx_t            resp_rd,
   output logic                stall,
   output logic                full,
   output logic                empty,
   output logic [NUM_REGS-1:0] pending,
   output logic                err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   typedef logic [CW-1:0] cnt_t;

   logic                w_full;
   logic                w_empty;
   reg_idx_t            w_head;
   logic                w_push;
   logic                w_pop;
   logic                w_err_set;
   cnt_t                r_count [NUM_REGS];
   cnt_t                w_count_nxt [NUM_REGS];
   logic [NUM_REGS-1:0] w_pending_nxt;
   logic [NUM_REGS-1:0] r_pending;
   logic                r_err;
   logic                w_rs_hz;
   logic                w_rt_hz;
   logic                w_bypass_hz;
   logic                w_full_hz;

   // A full tracker still accepts an issue when the head retires that cycle.
   assign w_push    = iss_valid && (!w_full || resp_valid);
   assign w_pop     = resp_valid && !w_empty;
   assign w_err_set = (iss_valid && w_full && !resp_valid) ||
                      (resp_valid && w_empty);

   tag_fifo #(
      .DEPTH (DEPTH)
   ) u_tag_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (w_push),
      .push_tag (iss_rd),
      .pop      (w_pop),
      .full     (w_full),
      .empty    (w_empty),
      .head     (w_head)
   );

   // Register 0 never counts; a matching issue and retire cancel out.
   always_comb begin
      for (int unsigned n = 0; n < NUM_REGS; n++) begin
         w_count_nxt[n] = r_count[n];
         if (n != 0) begin
            if (w_push && (iss_rd == reg_idx_t'(n)))
               w_count_nxt[n] = w_count_nxt[n] + cnt_t'(1);
            if (w_pop && (w_head == reg_idx_t'(n)))
               w_count_nxt[n] = w_count_nxt[n] - cnt_t'(1);
         end
         w_pending_nxt[n] = (w_count_nxt[n] != '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned n = 0; n < NUM_REGS; n++) r_count[n] <= '0;
         r_pending <= '0;
         r_err     <= 1'b0;
      end else begin
         for (int unsigned n = 0; n < NUM_REGS; n++) r_count[n] <= w_count_nxt[n];
         r_pending <= w_pending_nxt;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   // The bypass term covers a load issuing in the same cycle its destination
   // is read in ID, before pending can show it.
   always_comb begin
      w_rs_hz     = ID_UseRs && (ID_RegRs != '0) && r_pending[ID_RegRs];
      w_rt_hz     = ID_UseRt && (ID_RegRt != '0) && r_pending[ID_RegRt];
      w_bypass_hz = iss_valid && (iss_rd != '0) &&
                    ((ID_UseRs && (iss_rd == ID_RegRs)) ||
                     (ID_UseRt && (iss_rd == ID_RegRt)));
      w_full_hz   = w_full && !resp_valid;
   end

   assign stall   = w_rs_hz || w_rt_hz || w_bypass_hz || w_full_hz;
   assign resp_rd = w_empty ? '0 : w_head;
   assign full    = w_full;
   assign empty   = w_empty;
   assign pending = r_pending;
   assign err     = r_err;

endmodule : load_scoreboard

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;
   import load_scoreboard_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  ID_RegRs;
   logic [4:0]  ID_RegRt;
   logic        ID_UseRs;
   logic        ID_UseRt;
   logic        resp_valid;
   logic [4:0]  resp_rd;
   logic        stall;
   logic        full;
   logic        empty;
   logic [31:0] pending;
   logic        err;

   always #5 clk = ~clk;

   load_scoreboard #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .iss_valid  (iss_valid),
      .iss_rd     (iss_rd),
      .ID_RegRs   (ID_RegRs),
      .ID_RegRt   (ID_RegRt),
      .ID_UseRs   (ID_UseRs),
      .ID_UseRt   (ID_UseRt),
      .resp_valid (resp_valid),
      .resp_rd    (resp_rd),
      .stall      (stall),
      .full       (full),
      .empty      (empty),
      .pending    (pending),
      .err        (err)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   // Reference: queue of outstanding destination tags in issue order.
   logic [4:0] m_q[$];
   bit         m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_pending();
      logic [31:0] p = '0;
      foreach (m_q[i]) if (m_q[i] != 0) p[m_q[i]] = 1'b1;
      return p;
   endfunction

   function automatic logic m_stall();
      logic [31:0] p = m_pending();
      logic s = 1'b0;
      if (ID_UseRs && ID_RegRs != 0 && p[ID_RegRs]) s = 1'b1;
      if (ID_UseRt && ID_RegRt != 0 && p[ID_RegRt]) s = 1'b1;
      if (iss_valid && iss_rd != 0 &&
          ((ID_UseRs && iss_rd == ID_RegRs) || (ID_UseRt && iss_rd == ID_RegRt))) s = 1'b1;
      if (m_q.size() == DEPTH && !resp_valid) s = 1'b1;
      return s;
   endfunction

   task automatic check_all();
      chk("resp_rd", 32'(resp_rd), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      chk("full",    32'(full),    32'(m_q.size() == DEPTH));
      chk("empty",   32'(empty),   32'(m_q.size() == 0));
      chk("pending", pending,      m_pending());
      chk("err",     32'(err),     32'(m_err));
      chk("stall",   32'(stall),   32'(m_stall()));
   endtask

   task automatic drive(input bit iv, input logic [4:0] rd, input bit rv,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input bit urs, input bit urt);
      iss_valid  = iv;
      iss_rd     = rd;
      resp_valid = rv;
      ID_RegRs   = rs;
      ID_RegRt   = rt;
      ID_UseRs   = urs;
      ID_UseRt   = urt;
      #2;
      check_all();
   endtask

   // Clock edge, then advance the reference by the rules of issue/response.
   task automatic commit();
      bit was_full  = (m_q.size() == DEPTH);
      bit was_empty = (m_q.size() == 0);
      @(posedge clk);
      if (resp_valid && !was_empty) void'(m_q.pop_front());
      if (iss_valid && (!was_full || resp_valid)) m_q.push_back(iss_rd);
      if ((iss_valid && was_full && !resp_valid) || (resp_valid && was_empty)) m_err = 1'b1;
      @(negedge clk);
   endtask

   task automatic step(input bit iv, input logic [4:0] rd, input bit rv);
      drive(iv, rd, rv, 5'd0, 5'd0, 1'b0, 1'b0);
      commit();
   endtask

   task automatic do_reset();
      drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      rst = 1'b1;
      m_q.delete();
      m_err = 1'b0;
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      m_err = 1'b0;
      iss_valid = 0; iss_rd = 0; resp_valid = 0;
      ID_RegRs = 0; ID_RegRt = 0; ID_UseRs = 0; ID_UseRt = 0;
      #1;
      chk("rst_empty",   32'(empty),   32'd1);
      chk("rst_full",    32'(full),    32'd0);
      chk("rst_resp_rd", 32'(resp_rd), 32'd0);
      chk("rst_pending", pending,      32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single load with same-cycle bypass and later retire
      drive(1'b1, 5'd5, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
      chk("single_bypass_stall", 32'(stall), 32'd1);
      commit();
      drive(1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
      chk("single_pending5", 32'(pending[5]), 32'd1);
      commit();
      drive(1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
      commit();
      drive(1'b0, 5'd0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0);
      chk("single_resp_rd", 32'(resp_rd), 32'd5);
      commit();
      drive(1'b0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0);
      chk("single_cleared", 32'(pending[5]), 32'd0);
      chk("single_nostall", 32'(stall), 32'd0);
      commit();

      // Fill then overflow
      do_reset();
      for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 1'b0);
      drive(1'b0, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_stall_unrelated", 32'(stall), 32'd1);
      commit();
      step(1'b1, 5'd6, 1'b0);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_head", 32'(resp_rd), 32'd1);
      chk("ovf_pending", pending, 32'h0000_001E);
      commit();

      // Issue and retire together while full
      do_reset();
      for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 1'b0);
      step(1'b1, 5'd8, 1'b1);
      drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("simul_full", 32'(full), 32'd1);
      chk("simul_err", 32'(err), 32'd0);
      chk("simul_head", 32'(resp_rd), 32'd2);
      chk("simul_pending", pending, 32'h0000_011C);
      commit();

      // Duplicate destination
      do_reset();
      step(1'b1, 5'd7, 1'b0);
      step(1'b1, 5'd7, 1'b0);
      step(1'b0, 5'd0, 1'b1);
      chk("dup_still_pending", 32'(pending[7]), 32'd1);
      step(1'b0, 5'd0, 1'b1);
      chk("dup_cleared", 32'(pending[7]), 32'd0);

      // x0 load and empty response
      do_reset();
      step(1'b1, 5'd0, 1'b0);
      chk("x0_pending", pending, 32'd0);
      chk("x0_not_empty", 32'(empty), 32'd0);
      drive(1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0);
      chk("x0_resp_rd", 32'(resp_rd), 32'd0);
      commit();
      chk("x0_no_err", 32'(err), 32'd0);
      step(1'b0, 5'd0, 1'b1);
      chk("underflow_err", 32'(err), 32'd1);

      // Asynchronous reset with loads outstanding
      do_reset();
      step(1'b1, 5'd3, 1'b0);
      step(1'b1, 5'd4, 1'b0);
      step(1'b1, 5'd5, 1'b0);
      drive(1'b0, 5'd0, 1'b0, 5'd3, 5'd4, 1'b1, 1'b1);
      rst = 1'b1;
      #1;
      chk("arst_empty",   32'(empty),   32'd1);
      chk("arst_pending", pending,      32'd0);
      chk("arst_err",     32'(err),     32'd0);
      chk("arst_stall",   32'(stall),   32'd0);
      m_q.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 5'd0, 1'b1);
      chk("arst_late_resp_err", 32'(err), 32'd1);

      // Randomized traffic against the reference queue
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         if ($urandom_range(0, 249) == 0) do_reset();
         drive($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)),
               $urandom_range(0, 99) < 40,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         commit();
         if (m_err && $urandom_range(0, 19) == 0) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_load_scoreboard
